// File: rtl/vc_pop_arbiter_pkg.sv
// Shared definitions for the VC0/VC1 pop arbiter: state encoding and default word width.
package vc_pop_arbiter_pkg;

  localparam int DATA_W_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

endpackage

// File: rtl/vc_pop_arbiter.sv
// Pops VC0/VC1 FIFOs onto the single Demux_D0_D1 path: VC0 priority with a burst limit,
// combinational Pausa stall, and a one-deep registered data/valid pipeline.
module vc_pop_arbiter
  import vc_pop_arbiter_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              active,
  input  logic              fifo_empty_vc0,
  input  logic              fifo_empty_vc1,
  input  logic [DATA_W-1:0] data_vc0,
  input  logic [DATA_W-1:0] data_vc1,
  input  logic              pausa_d0,
  input  logic              pausa_d1,
  output logic              pop_vc0,
  output logic              pop_vc1,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              grant_vc1
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic               pending_q, pending_sel_q;
  logic [DATA_W-1:0]  data_out_q;
  logic               valid_out_q, grant_vc1_q;
  logic               stall;

  assign stall = pausa_d0 | pausa_d1;

  // Next-state and issue decision; pops only ever leave the RUN state.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    pop_vc0     = 1'b0;
    pop_vc1     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (active && (!fifo_empty_vc0 || !fifo_empty_vc1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stall) begin
          state_d = ST_PAUSED;
        end else if (!active || (fifo_empty_vc0 && fifo_empty_vc1)) begin
          state_d = ST_IDLE;
        end else if (!fifo_empty_vc0 && (fifo_empty_vc1 || (burst_cnt_q < MAX_CNT))) begin
          pop_vc0 = 1'b1;
        end else begin
          pop_vc1 = 1'b1;
        end
      end
      ST_PAUSED: begin
        if (!active)     state_d = ST_IDLE;
        else if (!stall) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase

    // The burst only counts while VC1 is actually waiting.
    if (fifo_empty_vc1 || pop_vc1) burst_cnt_d = '0;
    else if (pop_vc0 && (burst_cnt_q < MAX_CNT)) burst_cnt_d = burst_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= ST_IDLE;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // FIFO read data arrives the cycle after the pop; pending_sel picks which VC it came from.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pending_q     <= 1'b0;
      pending_sel_q <= 1'b0;
      data_out_q    <= '0;
      valid_out_q   <= 1'b0;
      grant_vc1_q   <= 1'b0;
    end else begin
      pending_q     <= pop_vc0 | pop_vc1;
      pending_sel_q <= pop_vc1;
      valid_out_q   <= pending_q;
      if (pending_q) data_out_q <= pending_sel_q ? data_vc1 : data_vc0;
      if (pop_vc0 || pop_vc1) grant_vc1_q <= pop_vc1;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign grant_vc1 = grant_vc1_q;

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Directed bench for vc_pop_arbiter with behavioural VC FIFOs and hand-computed expectations.
module tb_vc_pop_arbiter;
  import vc_pop_arbiter_pkg::*;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         reset_L = 1'b0;
  logic         active = 1'b0;
  logic         fifo_empty_vc0 = 1'b1;
  logic         fifo_empty_vc1 = 1'b1;
  logic [W-1:0] data_vc0 = '0;
  logic [W-1:0] data_vc1 = '0;
  logic         pausa_d0 = 1'b0;
  logic         pausa_d1 = 1'b0;
  logic         pop_vc0, pop_vc1, valid_out, grant_vc1;
  logic [W-1:0] data_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W-1:0] vc0_q[$];
  logic [W-1:0] vc1_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic         pop_seq[$];
  int           pop_cyc[$];
  int           val_cyc[$];

  vc_pop_arbiter #(.DATA_W(W), .MAX_BURST(4), .CNT_W(4)) dut (
    .clk(clk), .reset_L(reset_L), .active(active),
    .fifo_empty_vc0(fifo_empty_vc0), .fifo_empty_vc1(fifo_empty_vc1),
    .data_vc0(data_vc0), .data_vc1(data_vc1),
    .pausa_d0(pausa_d0), .pausa_d1(pausa_d1),
    .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
    .data_out(data_out), .valid_out(valid_out), .grant_vc1(grant_vc1)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // FIFO model: read data is registered on the pop, empty reflects the post-pop occupancy
  always @(posedge clk) begin
    if (pop_vc0 && vc0_q.size() > 0) data_vc0 <= vc0_q.pop_front();
    if (pop_vc1 && vc1_q.size() > 0) data_vc1 <= vc1_q.pop_front();
    fifo_empty_vc0 <= (vc0_q.size() == 0);
    fifo_empty_vc1 <= (vc1_q.size() == 0);
  end

  // pop log, cycle counter and pop legality
  always @(posedge clk) begin
    if (pop_vc0) begin pop_seq.push_back(1'b0); pop_cyc.push_back(cyc); end
    if (pop_vc1) begin pop_seq.push_back(1'b1); pop_cyc.push_back(cyc); end
    if (reset_L) begin
      checks++;
      assert (!(pop_vc0 && pop_vc1) && !(pop_vc0 && fifo_empty_vc0) && !(pop_vc1 && fifo_empty_vc1))
      else begin
        errors++;
        $error("FAIL pop_legal: observed pop0=%0b pop1=%0b e0=%0b e1=%0b expected=legal_pop",
               pop_vc0, pop_vc1, fifo_empty_vc0, fifo_empty_vc1);
      end
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (valid_out) begin
      got_q.push_back(data_out);
      val_cyc.push_back(cyc);
    end
  end

  // scoreboard helpers
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_logs();
    exp_q.delete(); got_q.delete(); pop_seq.delete(); pop_cyc.delete(); val_cyc.delete();
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pop(input string tag);
    int k = 0;
    while (!(pop_vc0 || pop_vc1) && k < 50) begin
      step();
      k++;
    end
    chk(tag, (k < 50), 1);
  endtask

  task automatic check_order(input string tag);
    int bad = 0;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    chk({tag, "_order"}, bad, 0);
  endtask

  task automatic check_seq(input string tag, input int n, input logic [15:0] expv);
    logic [15:0] act = '0;
    chk({tag, "_pops"}, pop_seq.size(), n);
    for (int i = 0; i < pop_seq.size() && i < 16; i++) act = {act[14:0], pop_seq[i]};
    chk({tag, "_pattern"}, act, expv);
  endtask

  // directed stimulus
  initial begin
    vc0_q.push_back(6'd9);
    active = 1'b1;
    repeat (3) step();
    chk("rst_pop0", pop_vc0, 0);
    chk("rst_pop1", pop_vc1, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_grant", grant_vc1, 0);
    vc0_q.delete();
    active = 1'b0;
    repeat (2) step();
    @(negedge clk);
    reset_L = 1'b1;
    repeat (2) step();

    // 1: three VC0 words, VC1 empty
    clear_logs();
    @(negedge clk);
    vc0_q.push_back(6'd5); vc0_q.push_back(6'd6); vc0_q.push_back(6'd7);
    exp_q.push_back(6'd5); exp_q.push_back(6'd6); exp_q.push_back(6'd7);
    active = 1'b1;
    repeat (8) step();
    check_seq("t1", 3, 16'b000);
    if (pop_cyc.size() == 3) begin
      chk("t1_consec1", pop_cyc[1] - pop_cyc[0], 1);
      chk("t1_consec2", pop_cyc[2] - pop_cyc[0], 2);
    end
    check_order("t1");
    for (int i = 0; i < 3; i++)
      if (i < val_cyc.size() && i < pop_cyc.size()) chk("t1_latency", val_cyc[i] - pop_cyc[i], 2);

    // 2: 8 + 8 words, burst limit 4
    clear_logs();
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      vc0_q.push_back(W'(i + 1));
      vc1_q.push_back(W'(i + 33));
    end
    exp_q = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd33, 6'd5, 6'd6, 6'd7, 6'd8,
              6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39, 6'd40};
    repeat (24) step();
    check_seq("t2", 16, 16'b0000_1000_0111_1111);
    check_order("t2");
    chk("t2_grant_vc1", grant_vc1, 1);

    // 3: pausa_d1 for three cycles while streaming VC0
    clear_logs();
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      vc0_q.push_back(W'(i + 10));
      exp_q.push_back(W'(i + 10));
    end
    step();
    wait_pop("t3_start");
    step(); step();
    @(negedge clk); pausa_d1 = 1'b1; #1;
    chk("t3_stall1_pop", pop_vc0, 0);
    chk("t3_stall1_valid", valid_out, 1);
    step();
    chk("t3_stall2_pop", pop_vc0, 0);
    chk("t3_inflight_valid", valid_out, 1);
    step();
    chk("t3_stall3_pop", pop_vc0, 0);
    chk("t3_stall3_valid", valid_out, 0);
    @(negedge clk); pausa_d1 = 1'b0; #1;
    chk("t3_release_pop", pop_vc0, 0);
    step();
    chk("t3_resume_pop", pop_vc0, 1);
    repeat (30) step();
    check_order("t3");

    // 4: active drops right after a pop
    clear_logs();
    @(negedge clk);
    for (int i = 0; i < 5; i++) vc0_q.push_back(W'(i + 50));
    step();
    wait_pop("t4_start");
    @(negedge clk); active = 1'b0; #1;
    chk("t4_nopop", pop_vc0, 0);
    chk("t4_valid_n1", valid_out, 0);
    step();
    chk("t4_valid_n2", valid_out, 1);
    chk("t4_data_n2", data_out, 50);
    step();
    chk("t4_valid_n3", valid_out, 0);
    repeat (4) step();
    chk("t4_pop_count", pop_seq.size(), 1);
    vc0_q.delete();
    repeat (3) step();

    // 5: empty FIFOs, then VC1 only
    clear_logs();
    @(negedge clk); active = 1'b1;
    repeat (4) step();
    chk("t5_empty_nopop", pop_seq.size(), 0);
    @(negedge clk); vc1_q.push_back(6'd63); #1;
    chk("t5_pre_pop1", pop_vc1, 0);
    step();
    chk("t5_empty_seen", fifo_empty_vc1, 0);
    chk("t5_idle_pop1", pop_vc1, 0);
    step();
    chk("t5_first_pop1", pop_vc1, 1);
    repeat (4) step();
    chk("t5_data", (got_q.size() == 1) ? 32'(got_q[0]) : 32'hffff, 63);

    // 6: asynchronous reset mid-stream
    clear_logs();
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      vc0_q.push_back(W'(i + 1));
      vc1_q.push_back(W'(i + 41));
    end
    step();
    wait_pop("t6_start");
    repeat (3) step();
    #2;
    reset_L = 1'b0;
    #1;
    chk("t6_rst_valid", valid_out, 0);
    chk("t6_rst_data", data_out, 0);
    chk("t6_rst_pop0", pop_vc0, 0);
    chk("t6_rst_pop1", pop_vc1, 0);
    chk("t6_rst_grant", grant_vc1, 0);
    vc0_q.delete(); vc1_q.delete();
    repeat (2) step();
    @(negedge clk); reset_L = 1'b1;
    step();
    clear_logs();
    @(negedge clk);
    for (int i = 0; i < 5; i++) vc0_q.push_back(W'(i + 1));
    vc1_q.push_back(6'd41); vc1_q.push_back(6'd42);
    exp_q = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd41, 6'd5, 6'd42};
    repeat (20) step();
    check_seq("t6", 7, 16'b000_0000_0000_0101);
    check_order("t6");
    chk("t6_grant_vc1", grant_vc1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
